// File: rtl/pipe_stage_register.sv
// Pipeline stage register with a valid/ready handshake, a two-entry skid buffer,
// a synchronous flush that inserts bubbles, and a saturating stall counter.
module pipe_stage_register #(
    parameter int CTRL_W           = 8,
    parameter int DATA_W           = 128,
    parameter int BUBBLE_ZERO_CTRL = 1,
    parameter int STALL_CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      ctrl_in,
    input  logic [DATA_W-1:0]      data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      ctrl_out,
    output logic [DATA_W-1:0]      data_out,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    state_t                  state_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [CTRL_W-1:0]       main_ctrl_q;
    logic [DATA_W-1:0]       main_data_q;
    logic [CTRL_W-1:0]       skid_ctrl_q;
    logic [DATA_W-1:0]       skid_data_q;
    logic [STALL_CNT_W-1:0]  stall_q;
    logic [STALL_CNT_W-1:0]  stall_d;
    logic                    accept_s;
    logic                    release_s;

    // Handshake qualifiers use only registered flags, so no input-to-output comb path.
    assign accept_s  = in_valid & in_ready_q;
    assign release_s = out_valid_q & out_ready;

    // Storage FSM: main entry feeds the outputs, skid absorbs one beat under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (flush) begin
            // Data registers hold their value to avoid needless toggling.
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_ctrl_q <= ctrl_in;
                        main_data_q <= data_in;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end else begin
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && release_s) begin
                        main_ctrl_q <= ctrl_in;
                        main_data_q <= data_in;
                        state_q     <= ST_ONE;
                    end else if (accept_s) begin
                        skid_ctrl_q <= ctrl_in;
                        skid_data_q <= data_in;
                        in_ready_q  <= 1'b0;
                        state_q     <= ST_FULL;
                    end else if (release_s) begin
                        if (BUBBLE_ZERO_CTRL != 0) begin
                            main_ctrl_q <= '0;
                        end else begin
                            main_ctrl_q <= main_ctrl_q;
                        end
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end else begin
                        state_q     <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (release_s) begin
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_ONE;
                    end else begin
                        state_q     <= ST_FULL;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    main_ctrl_q <= '0;
                    skid_ctrl_q <= '0;
                end
            endcase
        end
    end

    // Stall counter next state: count stalled cycles, stick at all-ones, ignore flush cycles.
    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && !flush && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign ctrl_out    = main_ctrl_q;
    assign data_out    = main_data_q;
    assign stall_count = stall_q;

endmodule
